scoreboard_ctrl: RTL and testbench
==================================

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning number of general registers tracked (index width 4).
REQ-002 SHALL have parameter CNT_W, default 2, meaning width of each per-register pending-write counter (max in-flight writers = 2^CNT_W-1).
REQ-003 SHALL have parameter BR_SLOTS, default 2, meaning decode bubble cycles inserted after an accepted branch (1..15).
REQ-004 SHALL have port: clk  in  1  single clock, all state on posedge.
REQ-005 SHALL have port: rst  in  1  reset; synchronous and active-low.
REQ-006 SHALL have ports: issue_v_i in 1 decode holds valid instruction; issue_rd_i in 4 destination index; issue_rs_i in 4 source index.
REQ-007 SHALL have ports: issue_wr_i in 1 instruction writes rd; issue_rdrd_i in 1 instruction reads rd; issue_rsrd_i in 1 instruction reads rs; issue_br_i in 1 instruction is a branch.
REQ-008 SHALL have ports: wb_i in 1 write-back enable; wb_r_i in 4 write-back register index.
REQ-009 SHALL have ports: stall_i in 1 stall from execute side; stall_o out 1 stall to fetch/decode; accept_o out 1 instruction issued this cycle.
REQ-010 SHALL have ports: busy_o out NREG registered per-register pending flags; err_o out 1 sticky write-back-underflow flag.

Function
REQ-011 hazard SHALL be: (issue_rdrd_i & pend[rd]) | (issue_rsrd_i & pend[rs]) | (issue_wr_i & cnt[rd]==max), pend[r] meaning cnt[r]!=0.
REQ-012 accept_o SHALL = issue_v_i & ~stall_i & ~hazard & state==RUN, combinational.
REQ-013 stall_o SHALL = stall_i | (issue_v_i & hazard) | state==BR_WAIT, combinational.
REQ-014 cnt[r] SHALL increment next cycle on accept with issue_wr_i and rd==r; decrement on wb_i with wb_r_i==r; both on the same r -> unchanged.
REQ-015 wb_i to a register with cnt==0 SHALL leave cnt at 0 and set err_o until reset.
REQ-016 busy_o[r] SHALL reflect cnt[r]!=0 as registered after the update (1-cycle latency from issue/wb).
REQ-017 FSM states SHALL be RUN and BR_WAIT; RUN->BR_WAIT on accept with issue_br_i, loading bubble counter with BR_SLOTS.
REQ-018 in BR_WAIT the bubble counter SHALL decrement each cycle stall_i is low, hold while stall_i is high, and return to RUN in the cycle after it reaches 1.
REQ-019 write-backs SHALL be processed in every state, including BR_WAIT and while stall_i is high.

Reset
REQ-020 with rst low at a clock edge: all cnt=0, busy_o=0, err_o=0, state=RUN, bubble counter=0; applies mid-branch-wait and mid-pending without exception.
REQ-021 during reset stall_o SHALL follow REQ-013 with reset state values (i.e. equal stall_i | hazard-free 0).

Configuration
REQ-022 macro SCOREBOARD_WB_BYPASS_EN: when defined, a read hazard on register r SHALL be cancelled if wb_i & wb_r_i==r & cnt[r]==1 in the same cycle (register file write-through); when undefined, that case SHALL stall one cycle.

Structure
REQ-023 shared package venus_pkg SHALL hold register-index width, NREG, CNT_W default and the RUN/BR_WAIT state encoding.
REQ-024 one sub-module pend_cnt (saturating up/down counter with underflow flag) SHALL be instantiated NREG times via generate.

Verification
REQ-025 issue wr r3, next cycle issue read rs=r3 -> stall_o=1, accept_o=0; wb r3 -> busy_o[3]=0 and read accepted next cycle.
REQ-026 with SCOREBOARD_WB_BYPASS_EN: read r3 in the same cycle as wb r3 (cnt=1) -> accept_o=1; without the macro -> stall_o=1 for one cycle.
REQ-027 three accepted writes to r5 (cnt=3), fourth write -> stalled; simultaneous issue-wr r5 and wb r5 at cnt=2 -> cnt stays 2.
REQ-028 accepted branch, BR_SLOTS=2 -> stall_o=1 exactly 2 cycles; stall_i high 3 cycles in the middle -> 5 cycles total.
REQ-029 wb r7 with cnt[7]=0 -> err_o=1 and remains set; rst low for one cycle -> err_o=0, busy_o=16'h0000.
REQ-030 rst low during BR_WAIT with pending r1 -> next cycle state RUN, stall_o=stall_i, busy_o=0.

Source files
------------

// File: rtl/scoreboard_ctrl_pkg.sv
// Shared definitions for the issue scoreboard: register index width, default
// sizes and the branch-wait FSM encoding.
package venus_pkg;

    localparam int IDX_W     = 4;
    localparam int NREG_DEF  = 16;
    localparam int CNT_W_DEF = 2;
    localparam int BUB_W     = 4;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } sb_state_e;

endpackage

// File: rtl/scoreboard_ctrl_if.sv
// Decode/write-back handshake bundle between the decode stage and the issue
// scoreboard.
interface scoreboard_ctrl_if
    import venus_pkg::*;
#(
    parameter int NREG = NREG_DEF
);
    logic             issue_v_i;
    logic [IDX_W-1:0] issue_rd_i;
    logic [IDX_W-1:0] issue_rs_i;
    logic             issue_wr_i;
    logic             issue_rdrd_i;
    logic             issue_rsrd_i;
    logic             issue_br_i;
    logic             wb_i;
    logic [IDX_W-1:0] wb_r_i;
    logic             stall_i;
    logic             stall_o;
    logic             accept_o;
    logic [NREG-1:0]  busy_o;
    logic             err_o;

    modport master (
        output issue_v_i, issue_rd_i, issue_rs_i, issue_wr_i, issue_rdrd_i,
               issue_rsrd_i, issue_br_i, wb_i, wb_r_i, stall_i,
        input  stall_o, accept_o, busy_o, err_o
    );

    modport slave (
        input  issue_v_i, issue_rd_i, issue_rs_i, issue_wr_i, issue_rdrd_i,
               issue_rsrd_i, issue_br_i, wb_i, wb_r_i, stall_i,
        output stall_o, accept_o, busy_o, err_o
    );
endinterface

// File: rtl/scoreboard_ctrl_pend_cnt.sv
// Per-register pending-write counter: saturating up/down count, registered
// busy flag and sticky underflow flag.
module pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             uflow
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;
    logic             uflow_r;
    logic             uflow_set_s;

    // Next count: simultaneous inc/dec cancel, both ends saturate
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_ONE;
                else                  cnt_nxt_s = cnt_r;
            end
            2'b01: begin
                if (cnt_r != CNT_ZERO) cnt_nxt_s = cnt_r - CNT_ONE;
                else                   cnt_nxt_s = cnt_r;
            end
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    assign uflow_set_s = dec & (cnt_r == CNT_ZERO);

    // Counter, busy and sticky underflow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            uflow_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (cnt_nxt_s != CNT_ZERO);
            uflow_r <= uflow_r | uflow_set_s;
        end
    end

    assign cnt   = cnt_r;
    assign busy  = busy_r;
    assign uflow = uflow_r;
endmodule

// File: rtl/scoreboard_ctrl.sv
// Issue scoreboard with branch-bubble FSM. Define SCOREBOARD_WB_BYPASS_EN to
// let a same-cycle final write-back clear a read hazard (write-through regfile).
module scoreboard_ctrl
    import venus_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int BR_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    scoreboard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(BR_SLOTS);
    localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1'b1);
    localparam logic [BUB_W-1:0] BUB_ZERO = {BUB_W{1'b0}};

    sb_state_e        state_r;
    sb_state_e        state_nxt_s;
    logic [BUB_W-1:0] bub_r;
    logic [BUB_W-1:0] bub_nxt_s;

    logic [CNT_W-1:0] cnt_s [NREG];
    logic [NREG-1:0]  busy_s;
    logic [NREG-1:0]  uflow_s;
    logic [NREG-1:0]  inc_s;
    logic [NREG-1:0]  dec_s;
    logic [NREG-1:0]  pend_s;
    logic [NREG-1:0]  full_s;
    logic [NREG-1:0]  byp_s;
    logic             hazard_s;
    logic             accept_s;
    logic             stall_s;

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        assign inc_s[g]  = accept_s & bus.issue_wr_i & (bus.issue_rd_i == IDX_W'(g));
        assign dec_s[g]  = bus.wb_i & (bus.wb_r_i == IDX_W'(g));
        assign pend_s[g] = (cnt_s[g] != CNT_ZERO);
        assign full_s[g] = (cnt_s[g] == CNT_MAX);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The last outstanding write lands this cycle and is forwarded
        assign byp_s[g]  = dec_s[g] & (cnt_s[g] == CNT_W'(1'b1));
`else
        assign byp_s[g]  = 1'b0;
`endif

        pend_cnt #(.CNT_W(CNT_W)) u_pend_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_s[g]),
            .dec   (dec_s[g]),
            .cnt   (cnt_s[g]),
            .busy  (busy_s[g]),
            .uflow (uflow_s[g])
        );
    end

    assign hazard_s = (bus.issue_rdrd_i & pend_s[bus.issue_rd_i] & ~byp_s[bus.issue_rd_i])
                    | (bus.issue_rsrd_i & pend_s[bus.issue_rs_i] & ~byp_s[bus.issue_rs_i])
                    | (bus.issue_wr_i   & full_s[bus.issue_rd_i]);

    // While rst is low the outputs reflect the reset state, not the stale registers
    assign accept_s = rst & bus.issue_v_i & ~bus.stall_i & ~hazard_s & (state_r == ST_RUN);
    assign stall_s  = bus.stall_i
                    | (rst & ((bus.issue_v_i & hazard_s) | (state_r == ST_BR_WAIT)));

    // Branch-bubble next state and countdown
    always_comb begin
        state_nxt_s = state_r;
        bub_nxt_s   = bub_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && bus.issue_br_i) begin
                    state_nxt_s = ST_BR_WAIT;
                    bub_nxt_s   = BUB_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    bub_nxt_s   = bub_r;
                end
            end
            ST_BR_WAIT: begin
                if (bus.stall_i) begin
                    bub_nxt_s = bub_r;
                end else if (bub_r <= BUB_ONE) begin
                    state_nxt_s = ST_RUN;
                    bub_nxt_s   = BUB_ZERO;
                end else begin
                    bub_nxt_s = bub_r - BUB_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                bub_nxt_s   = BUB_ZERO;
            end
        endcase
    end

    // FSM state and bubble counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_RUN;
            bub_r   <= BUB_ZERO;
        end else begin
            state_r <= state_nxt_s;
            bub_r   <= bub_nxt_s;
        end
    end

    assign bus.accept_o = accept_s;
    assign bus.stall_o  = stall_s;
    assign bus.busy_o   = busy_s;
    assign bus.err_o    = |uflow_s;
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed-vector bench for scoreboard_ctrl: the driver queues the expected
// outputs for each cycle, a monitor pops and compares them mid-cycle.
module tb_scoreboard_ctrl;
    logic clk;
    logic rst;

    typedef struct {
        logic        acc;
        logic        stall;
        logic [15:0] busy;
        logic        err;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests;
    int   n_fail;

    scoreboard_ctrl_if #(.NREG(16)) sb_if ();

    scoreboard_ctrl #(.NREG(16), .CNT_W(2), .BR_SLOTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic v, input logic wr, input logic rdrd,
                       input logic rsrd, input logic br, input logic [3:0] rd,
                       input logic [3:0] rs, input logic stl, input logic wb,
                       input logic [3:0] wbr, input logic e_acc, input logic e_stall,
                       input logic [15:0] e_busy, input logic e_err, input string nm);
        exp_t e;
        rst                = r;
        sb_if.issue_v_i    = v;
        sb_if.issue_wr_i   = wr;
        sb_if.issue_rdrd_i = rdrd;
        sb_if.issue_rsrd_i = rsrd;
        sb_if.issue_br_i   = br;
        sb_if.issue_rd_i   = rd;
        sb_if.issue_rs_i   = rs;
        sb_if.stall_i      = stl;
        sb_if.wb_i         = wb;
        sb_if.wb_r_i       = wbr;
        e.acc   = e_acc;
        e.stall = e_stall;
        e.busy  = e_busy;
        e.err   = e_err;
        e.nm    = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the queued expectation against the DUT at each falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if ({sb_if.accept_o, sb_if.stall_o, sb_if.busy_o, sb_if.err_o} !==
                    {mon_e.acc, mon_e.stall, mon_e.busy, mon_e.err}) begin
                    n_fail++;
                    $display("FAIL %s: got acc=%b stall=%b busy=%h err=%b, want acc=%b stall=%b busy=%h err=%b",
                             mon_e.nm, sb_if.accept_o, sb_if.stall_o, sb_if.busy_o, sb_if.err_o,
                             mon_e.acc, mon_e.stall, mon_e.busy, mon_e.err);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        sb_if.issue_v_i = 1'b0;  sb_if.issue_wr_i = 1'b0; sb_if.issue_rdrd_i = 1'b0;
        sb_if.issue_rsrd_i = 1'b0; sb_if.issue_br_i = 1'b0; sb_if.issue_rd_i = 4'd0;
        sb_if.issue_rs_i = 4'd0; sb_if.stall_i = 1'b0; sb_if.wb_i = 1'b0; sb_if.wb_r_i = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        //  r  v  wr rdrd rsrd br rd     rs     stl wb wbr    acc stall busy     err
        cyc(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 4'd0,  0, 1, 16'h0000, 0, "reset_stall");
        // read-after-write on r3
        cyc(1, 1, 1, 0, 0, 0, 4'd3, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "wr_r3");
        cyc(1, 1, 0, 0, 1, 0, 4'd0, 4'd3, 0, 0, 4'd0,  0, 1, 16'h0008, 0, "raw_r3_stall");
`ifdef SCOREBOARD_WB_BYPASS_EN
        cyc(1, 1, 0, 0, 1, 0, 4'd0, 4'd3, 0, 1, 4'd3,  1, 0, 16'h0008, 0, "raw_r3_wb_bypass");
`else
        cyc(1, 1, 0, 0, 1, 0, 4'd0, 4'd3, 0, 1, 4'd3,  0, 1, 16'h0008, 0, "raw_r3_wb_stall");
`endif
        cyc(1, 1, 0, 0, 1, 0, 4'd0, 4'd3, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "raw_r3_accept");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 0, "idle_a");
        // counter saturation on r5
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "wr5_1");
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0020, 0, "wr5_2");
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0020, 0, "wr5_3");
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0020, 0, "wr5_full");
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 1, 4'd5,  0, 1, 16'h0020, 0, "wr5_full_wb");
        cyc(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 0, 1, 4'd5,  1, 0, 16'h0020, 0, "wr5_wb5_same");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd5,  0, 0, 16'h0020, 0, "wb5_cnt2");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd5,  0, 0, 16'h0020, 0, "wb5_cnt1");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 0, "r5_drained");
        // branch bubbles, plain then with stall_i in the middle
        cyc(1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "br_accept");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "br_bubble1");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "br_bubble2");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "br_resume");
        cyc(1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "br2_accept");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "br2_b1");
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 4'd0,  0, 1, 16'h0000, 0, "br2_hold");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "br2_b2");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "br2_resume");
        // write-back underflow, sticky until reset
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd7,  0, 0, 16'h0000, 0, "wb7_uflow");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 1, "err_set");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 1, "err_sticky");
        cyc(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 1, "err_rst_cycle");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 0, "err_cleared");
        // reset during branch wait with r1 pending
        cyc(1, 1, 1, 0, 0, 0, 4'd1, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "wr_r1");
        cyc(1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0002, 0, "br_r1_pend");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0002, 0, "brwait_r1");
        cyc(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0002, 0, "rst_in_brwait");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 4'd0,  0, 1, 16'h0000, 0, "post_rst_stall_i");
        cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "post_rst_run");
        // write-back honoured during branch wait and stall_i
        cyc(1, 1, 1, 0, 0, 0, 4'd2, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "wr_r2");
        cyc(1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0004, 0, "br_r2_pend");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 4'd2,  0, 1, 16'h0004, 0, "wb2_brwait_stall");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "brwait_b1");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0000, 0, "brwait_b2");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 0, "brwait_done");
        // hazard through the rd-read port
        cyc(1, 1, 1, 0, 0, 0, 4'd6, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "wr_r6");
        cyc(1, 1, 0, 1, 0, 0, 4'd6, 4'd0, 0, 0, 4'd0,  0, 1, 16'h0040, 0, "rdrd_r6_stall");
        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd6,  0, 0, 16'h0040, 0, "wb_r6");
        cyc(1, 1, 0, 1, 0, 0, 4'd6, 4'd0, 0, 0, 4'd0,  1, 0, 16'h0000, 0, "rdrd_r6_accept");

        cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 16'h0000, 0, "final_idle");
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
